// File: rtl/io_sweep_pkg.sv
// io_sweep shared types, constants and MISR step.
// Used by the driver RTL and its bench.
package io_sweep_pkg;

  localparam int MISR_MAX_W = 32;
  localparam int DEF_OUT_W = 20;
  localparam logic [DEF_OUT_W-1:0] DEF_POLY = 20'h00009;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CAPTURE,
    DONE
  } sweep_state_t;

  // One MISR step at width w (w <= MISR_MAX_W), upper bits zeroed.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] resp,
    input logic [MISR_MAX_W-1:0] poly = MISR_MAX_W'(DEF_POLY),
    input int unsigned w = DEF_OUT_W
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] nxt;
    logic top;
    mask = (w >= MISR_MAX_W) ? '1
         : ((MISR_MAX_W'(1) << w) - MISR_MAX_W'(1));
    top = sig[5'(w - 1)];
    nxt = (sig << 1) ^ (top ? poly : '0) ^ resp;
    return nxt & mask;
  endfunction

endpackage

// File: rtl/io_sweep_driver_if.sv
// Stimulus/response bus between sweep driver and design.
// Log read port exists only with IO_SWEEP_LOG_EN.
interface io_sweep_driver_if #(
  parameter int IN_W = 3,
  parameter int OUT_W = 20
);
  logic             start;
  logic [IN_W-1:0]  stim_data;
  logic [OUT_W-1:0] resp_data;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] signature;
`ifdef IO_SWEEP_LOG_EN
  logic [IN_W-1:0]  rd_addr;
  logic [OUT_W-1:0] rd_data;

  modport master (
    input  start, resp_data, rd_addr,
    output stim_data, busy, done, signature, rd_data
  );
  modport slave (
    output start, resp_data, rd_addr,
    input  stim_data, busy, done, signature, rd_data
  );
`else
  modport master (
    input  start, resp_data,
    output stim_data, busy, done, signature
  );
  modport slave (
    output start, resp_data,
    input  stim_data, busy, done, signature
  );
`endif
endinterface

// File: rtl/io_sweep_misr.sv
// Signature register: clear to zero, or fold one response in.
// Clear wins over update.
module io_sweep_misr
  import io_sweep_pkg::*;
#(
  parameter int OUT_W = 20,
  parameter logic [OUT_W-1:0] POLY = OUT_W'(DEF_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             upd_i,
  input  logic [OUT_W-1:0] resp_i,
  output logic [OUT_W-1:0] sig_o
);

  logic [OUT_W-1:0] sig_q;
  logic [OUT_W-1:0] sig_d;

  // Next signature: reseed, step, or hold.
  always_comb begin
    sig_d = sig_q;
    unique case (1'b1)
      clr_i: sig_d = '0;
      upd_i: sig_d = OUT_W'(misr_next(
               MISR_MAX_W'(sig_q),
               MISR_MAX_W'(resp_i),
               MISR_MAX_W'(POLY),
               OUT_W));
      default: sig_d = sig_q;
    endcase
  end

  // Signature state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/io_sweep_driver.sv
// Sweeps stim_data over all codes, MISR-folds resp_data.
// IO_SWEEP_LOG_EN adds a per-code response log.
module io_sweep_driver
  import io_sweep_pkg::*;
#(
  parameter int IN_W = 3,
  parameter int OUT_W = 20,
  parameter int SETTLE = 1,
  parameter logic [OUT_W-1:0] POLY = OUT_W'(DEF_POLY)
) (
  input logic clk,
  input logic rst_n,
  io_sweep_driver_if.master bus
);

  localparam int CW = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  sweep_state_t    state_q;
  logic [IN_W-1:0] stim_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;

  logic last_code;
  logic misr_clr;
  logic misr_upd;

  assign last_code = &stim_q;
  assign misr_clr = (state_q == IDLE) && bus.start;
  assign misr_upd = (state_q == CAPTURE);

  // Sweep FSM with stimulus, settle counter and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= DRIVE;
            stim_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q == CNT_LAST) state_q <= CAPTURE;
          else cnt_q <= cnt_q + 1'b1;
        end
        CAPTURE: begin
          if (last_code) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= DRIVE;
            stim_q  <= stim_q + 1'b1;
            cnt_q   <= '0;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  io_sweep_misr #(
    .OUT_W (OUT_W),
    .POLY  (POLY)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (misr_clr),
    .upd_i  (misr_upd),
    .resp_i (bus.resp_data),
    .sig_o  (bus.signature)
  );

  assign bus.stim_data = stim_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifdef IO_SWEEP_LOG_EN
  logic [OUT_W-1:0] log_q [2**IN_W];

  // Response log, written per capture, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**IN_W; i++) log_q[i] <= '0;
    end else if (misr_upd) begin
      log_q[stim_q] <= bus.resp_data;
    end
  end

  assign bus.rd_data = log_q[bus.rd_addr];
`endif

endmodule

// File: tb/tb_io_sweep_driver.sv
// Scoreboard bench for io_sweep_driver (SETTLE=1 and 3).
// Define IO_SWEEP_LOG_EN to exercise the response log.
module tb_io_sweep_driver;

  localparam int SA = 1;
  localparam int SB = 3;

  typedef struct {
    logic [19:0] sig;
    int          busy_len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_sweep_driver_if #(.IN_W(3), .OUT_W(20)) ifa ();
  io_sweep_driver_if #(.IN_W(3), .OUT_W(20)) ifb ();

  io_sweep_driver #(
    .IN_W(3), .OUT_W(20), .SETTLE(SA), .POLY(20'h00009)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.master)
  );

  io_sweep_driver #(
    .IN_W(3), .OUT_W(20), .SETTLE(SB), .POLY(20'h00009)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.master)
  );

  int mode_a = 0;
  logic [19:0] stim_a_ext;
  assign stim_a_ext = {17'b0, ifa.stim_data};
  assign ifa.resp_data = (mode_a == 0) ? 20'h00001
                       : (mode_a == 1) ? 20'h00000
                       : stim_a_ext * 20'd3;
  assign ifb.resp_data = 20'h00001;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  int busy_a, done_cnt_a;
  int hist_a[8];
  logic bad_a, ovl_a, pbusy_a;
  logic [2:0] prev_a;
  exp_t ea;

  // Monitor A: collect per-sweep facts, score on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_a = 0;
      foreach (hist_a[i]) hist_a[i] = 0;
      bad_a = 1'b0; ovl_a = 1'b0; pbusy_a = 1'b0;
    end else begin
      if (ifa.busy && ifa.done) ovl_a = 1'b1;
      if (ifa.busy) begin
        busy_a++;
        hist_a[ifa.stim_data]++;
        if (!pbusy_a && ifa.stim_data != 3'd0) bad_a = 1'b1;
        if (pbusy_a && ifa.stim_data != prev_a
            && ifa.stim_data != prev_a + 3'd1) bad_a = 1'b1;
        prev_a = ifa.stim_data;
      end
      pbusy_a = ifa.busy;
      if (ifa.done) begin
        done_cnt_a++;
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_done actual=1 required=0");
        end else begin
          ea = qa.pop_front();
          chk("a_signature", ifa.signature, ea.sig);
          chk("a_busy_len", busy_a, ea.busy_len);
          chk("a_stim_order", bad_a, 0);
          chk("a_busy_done_overlap", ovl_a, 0);
          for (int i = 0; i < 8; i++)
            chk($sformatf("a_hold_code%0d", i), hist_a[i], SA + 1);
        end
        busy_a = 0;
        foreach (hist_a[i]) hist_a[i] = 0;
        bad_a = 1'b0; ovl_a = 1'b0;
      end
    end
  end

  int busy_b, done_cnt_b;
  int hist_b[8];
  logic bad_b, ovl_b, pbusy_b;
  logic [2:0] prev_b;
  exp_t eb;

  // Monitor B: same checks for the SETTLE=3 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_b = 0;
      foreach (hist_b[i]) hist_b[i] = 0;
      bad_b = 1'b0; ovl_b = 1'b0; pbusy_b = 1'b0;
    end else begin
      if (ifb.busy && ifb.done) ovl_b = 1'b1;
      if (ifb.busy) begin
        busy_b++;
        hist_b[ifb.stim_data]++;
        if (!pbusy_b && ifb.stim_data != 3'd0) bad_b = 1'b1;
        if (pbusy_b && ifb.stim_data != prev_b
            && ifb.stim_data != prev_b + 3'd1) bad_b = 1'b1;
        prev_b = ifb.stim_data;
      end
      pbusy_b = ifb.busy;
      if (ifb.done) begin
        done_cnt_b++;
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_done actual=1 required=0");
        end else begin
          eb = qb.pop_front();
          chk("b_signature", ifb.signature, eb.sig);
          chk("b_busy_len", busy_b, eb.busy_len);
          chk("b_stim_order", bad_b, 0);
          chk("b_busy_done_overlap", ovl_b, 0);
          for (int i = 0; i < 8; i++)
            chk($sformatf("b_hold_code%0d", i), hist_b[i], SB + 1);
        end
        busy_b = 0;
        foreach (hist_b[i]) hist_b[i] = 0;
        bad_b = 1'b0; ovl_b = 1'b0;
      end
    end
  end

  task automatic pulse_a();
    @(negedge clk) ifa.start = 1'b1;
    @(negedge clk) ifa.start = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk) ifb.start = 1'b1;
    @(negedge clk) ifb.start = 1'b0;
  endtask

  task automatic wait_done_a(input string name);
    int t0 = done_cnt_a;
    int n = 0;
    while (done_cnt_a == t0 && n < 300) begin
      @(negedge clk); n++;
    end
    if (done_cnt_a == t0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    @(negedge clk);
  endtask

  task automatic wait_done_b(input string name);
    int t0 = done_cnt_b;
    int n = 0;
    while (done_cnt_b == t0 && n < 300) begin
      @(negedge clk); n++;
    end
    if (done_cnt_b == t0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=hung required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bh, dc, n;
    done_cnt_a = 0;
    done_cnt_b = 0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
`ifdef IO_SWEEP_LOG_EN
    ifa.rd_addr = '0;
    ifb.rd_addr = '0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stim", ifa.stim_data, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_sig", ifa.signature, 0);
    chk("rst_b_busy", ifb.busy, 0);

    bh = 0;
    repeat (10) @(negedge clk) if (ifa.busy || ifb.busy) bh++;
    chk("idle_busy_cycles", bh, 0);

    // Constant response 1: signature fills ones, 0xFF.
    mode_a = 0;
    qa.push_back('{20'h000FF, 16});
    pulse_a();
    wait_done_a("const");

    // Zero response: signature stays zero.
    mode_a = 1;
    qa.push_back('{20'h00000, 16});
    pulse_a();
    wait_done_a("zero");

    // SETTLE=3 with a second start mid-sweep.
    qb.push_back('{20'h000FF, 32});
    dc = done_cnt_b;
    pulse_b();
    repeat (10) @(negedge clk);
    pulse_b();
    wait_done_b("settle");
    bh = 0;
    repeat (20) @(negedge clk) if (ifb.busy) bh++;
    chk("b_no_restart_busy", bh, 0);
    chk("b_single_done", done_cnt_b - dc, 1);

    // Reset while driving code 4.
    mode_a = 0;
    qa.push_back('{20'h000FF, 16});
    pulse_a();
    n = 0;
    while (ifa.stim_data != 3'd4 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("midrst_reached_code4", ifa.stim_data, 4);
    dc = done_cnt_a;
    rst_n = 1'b0;
    #1;
    chk("midrst_stim", ifa.stim_data, 0);
    chk("midrst_sig", ifa.signature, 0);
    chk("midrst_busy", ifa.busy, 0);
    qa.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_cnt_a - dc, 0);

    // Fresh sweep with resp = 3*stim: signature 0xFD.
    mode_a = 2;
    qa.push_back('{20'h000FD, 16});
    pulse_a();
    wait_done_a("after_rst");

`ifdef IO_SWEEP_LOG_EN
    ifa.rd_addr = 3'd5; #1;
    chk("log_addr5", ifa.rd_data, 20'h0000F);
    ifa.rd_addr = 3'd7; #1;
    chk("log_addr7", ifa.rd_data, 20'h00015);
    ifa.rd_addr = 3'd2; #1;
    chk("log_addr2", ifa.rd_data, 20'h00006);
    ifb.rd_addr = 3'd6; #1;
    chk("log_b_addr6", ifb.rd_data, 20'h00001);
`endif

    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_sweep_driver.md
# io_sweep_driver

Stimulus/response harness block for the generated combinational designs: it drives the design's narrow `input_data` bus through every code and receives its wide `output_data` response, so it is the opposite end of that interface. On `start` it walks `stim_data` from 0 to 2^IN_W−1 and waits a programmable settle time per code. It samples `resp_data` once per code and folds each sample into a MISR signature for on-chip comparison against a golden value.

## Interface
- `IN_W`, default 3: stimulus width; sweep length is 2^IN_W codes.
- `OUT_W`, default 20: response and signature width.
- `SETTLE`, default 1: DRIVE cycles per code before capture; legal range is ≥1.
- `POLY`, default 20'h00009: MISR feedback polynomial, OUT_W bits.
- `clk` (input, 1): clock, rising edge.
- `rst_n` (input, 1): asynchronous active-low reset.
- `start` (input, 1): sweep request; only sampled in IDLE.
- `stim_data` (output, IN_W): drives the DUT `input_data`.
- `resp_data` (input, OUT_W): DUT `output_data`; sampled only in CAPTURE.
- `busy` (output, 1): high from the sweep's first DRIVE cycle through its last CAPTURE cycle.
- `done` (output, 1): one-cycle pulse after the final capture.
- `signature` (output, OUT_W): MISR value; holds after `done` until the next `start`.
- `rd_addr` (input, IN_W): log read address; present only with IO_SWEEP_LOG_EN.
- `rd_data` (output, OUT_W): logged response; present only with IO_SWEEP_LOG_EN.

## Operation
- FSM states are IDLE, DRIVE, CAPTURE and DONE.
  - IDLE → DRIVE when `start`=1. On that edge: `stim_data`←0, `signature`←0, settle counter←0.
  - DRIVE → CAPTURE when the settle counter reaches SETTLE−1. Otherwise the counter increments.
  - CAPTURE → DRIVE if `stim_data` ≠ 2^IN_W−1. On that edge `stim_data` increments and the counter clears.
  - CAPTURE → DONE on the last code. `stim_data` holds its last value.
  - DONE → IDLE unconditionally.
- MISR update occurs on the CAPTURE edge only. Next value = ((sig << 1) truncated to OUT_W) XOR (sig[OUT_W−1] ? POLY : 0) XOR `resp_data`.
- `start` is ignored in DRIVE, CAPTURE and DONE. It is not queued.
- A new `start` in IDLE after a sweep reseeds the signature to 0.
- `stim_data` changes only on DRIVE entry from IDLE or from CAPTURE. It is stable for all SETTLE+1 cycles of each code.
- Arithmetic: the stimulus counter wraps only at the end of the sweep and is never observable above 2^IN_W−1. The settle counter width is $clog2(SETTLE)+1.

## Timing
- Reset values: `stim_data`=0, `busy`=0, `done`=0, `signature`=0. FSM is in IDLE; the log is cleared when present.
- Reset mid-sweep aborts immediately to the reset values. No `done` is issued.
- Let E0 be the edge where `start` is sampled:
  - `busy`=1 from E0 to E0 + 2^IN_W·(SETTLE+1).
  - `done`=1 during the following single cycle.
  - `busy` and `done` are never high together.
- Per-code latency is SETTLE+1 cycles: SETTLE DRIVE cycles plus one CAPTURE cycle.
- `resp_data` is treated as combinational from `stim_data`. SETTLE=1 gives one full cycle of settling.
- `signature` reflects a capture on the edge after that CAPTURE cycle. It is final when `done` is high.
- All outputs are registered except `rd_data`.

## Configuration
- Macro: IO_SWEEP_LOG_EN.
- Defined: adds a 2^IN_W × OUT_W response log.
  - The log entry at index `stim_data` is written with `resp_data` on each CAPTURE edge.
  - `rd_data` = log[`rd_addr`], combinational, readable at any time.
  - The log is cleared by reset only, not by `start`.
- Undefined: no log storage and no `rd_addr`/`rd_data` ports. The signature path is unchanged.

## Structure
- Shared package `io_sweep_pkg` holds:
  - the state enum `sweep_state_t` (IDLE, DRIVE, CAPTURE, DONE);
  - the default POLY constant;
  - a `misr_next(sig, resp)` function shared with the bench reference model.
- One sub-module, `io_sweep_misr`: the signature register with load-zero and update-enable inputs.
- The FSM, counters and optional log live in the top module.

## Test plan
- Reset: hold `rst_n`=0 then release → all outputs 0 and IDLE. `start`=0 for 10 cycles → `busy` stays 0.
- Constant response: `resp_data`=20'h00001, SETTLE=1 → `busy` for 16 cycles, `done` in cycle 17, `signature`=20'h000FF.
- Zero response: `resp_data`=0 → `signature`=0. Check that `stim_data` steps 0..7, each code held exactly SETTLE+1 cycles.
- Settle and ignore: SETTLE=3, `start` pulsed again mid-sweep → `busy` for exactly 32 cycles, a single `done`, and no restart.
- Reset mid-sweep: assert `rst_n`=0 at code 4 → `stim_data`=0, `signature`=0, no `done`. A fresh `start` then completes normally.
- Log (IO_SWEEP_LOG_EN): `resp_data` = `stim_data` zero-extended ×3 → after `done`, `rd_addr`=5 reads 20'h0000F and `rd_addr`=7 reads 20'h00015.
